// File: rtl/mppt_pkg.sv
// +------------------------------------------------------------------+
// | mppt_pkg : SPI word field map, register selects, block defaults  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package mppt_pkg;

  localparam int BSEL_MSB  = 15;
  localparam int BSEL_LSB  = 14;
  localparam int RSEL_MSB  = 13;
  localparam int RSEL_LSB  = 12;
  localparam int VALUE_MSB = 11;
  localparam int VALUE_LSB = 0;

  localparam int CNT_W_DEF       = 12;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    REG_DUTY = 2'd0,
    REG_DT   = 2'd1,
    REG_CTRL = 2'd2,
    REG_RSVD = 2'd3
  } reg_sel_e;

endpackage

`default_nettype wire

// File: rtl/strobe_sync.sv
// +------------------------------------------------------------------+
// | strobe_sync : async strobe synchroniser + rising-edge pulse      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module strobe_sync
  import mppt_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic nreset,
  input  logic strobe,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], strobe};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Both terms are flop outputs, so the pulse is glitch-free for one cycle.
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/board_pwm.sv
// +------------------------------------------------------------------+
// | board_pwm : shadowed PWM with dead time, complementary gate pair |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module board_pwm
  import mppt_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] data,
  input  logic        load,
  input  logic        countglobal,
  output logic        gate_hi,
  output logic        gate_lo,
  output logic        period_start
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             load_pulse, cg_pulse;
  logic [CNT_W-1:0] value;
  reg_sel_e         rsel;
  logic             unused_bsel;
  logic             en_rise, wrap, raw, drive;

  logic [CNT_W-1:0] period_sh_q, period_sh_d, duty_sh_q, duty_sh_d, dt_sh_q, dt_sh_d;
  logic [CNT_W-1:0] period_act_q, period_act_d, duty_act_q, duty_act_d, dt_act_q, dt_act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dt_cnt_q, dt_cnt_d;
  logic             enable_q, enable_d, raw_q, raw_d;
  logic             gate_hi_q, gate_hi_d, gate_lo_q, gate_lo_d;
  logic             period_start_q, period_start_d;

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk    (clk),
    .nreset (nreset),
    .strobe (load),
    .pulse  (load_pulse)
  );

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cg (
    .clk    (clk),
    .nreset (nreset),
    .strobe (countglobal),
    .pulse  (cg_pulse)
  );

  assign unused_bsel = ^data[BSEL_MSB:BSEL_LSB];

  always_comb begin
    value = CNT_W'(data[VALUE_MSB:VALUE_LSB]);
    rsel  = reg_sel_e'(data[RSEL_MSB:RSEL_LSB]);

    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    dt_sh_d     = dt_sh_q;
    enable_d    = enable_q;

    if (cg_pulse) period_sh_d = value;
    if (load_pulse) begin
      case (rsel)
        REG_DUTY: duty_sh_d = value;
        REG_DT:   dt_sh_d   = value;
        REG_CTRL: enable_d  = data[0];
        default:  ;
      endcase
    end

    en_rise = enable_d & ~enable_q;
    wrap    = (period_act_q != '0) && (cnt_q == period_act_q);

    // Shadows are taken from the _d side so a same-cycle write lands at once.
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    dt_act_d     = dt_act_q;
    if (wrap || en_rise) begin
      period_act_d = period_sh_d;
      duty_act_d   = duty_sh_d;
      dt_act_d     = dt_sh_d;
    end

    if (en_rise || wrap || (period_act_q == '0)) cnt_d = '0;
    else                                        cnt_d = cnt_q + CNT_ONE;

    period_start_d = wrap;

    raw   = (cnt_q < duty_act_q);
    raw_d = en_rise ? 1'b0 : raw;

    if (en_rise)             dt_cnt_d = dt_act_d;
    else if (raw != raw_q)   dt_cnt_d = dt_act_q;
    else if (dt_cnt_q != '0) dt_cnt_d = dt_cnt_q - CNT_ONE;
    else                     dt_cnt_d = dt_cnt_q;

    // The enabling cycle itself is held low: raw still reflects the old count.
    drive     = enable_q && enable_d && (dt_cnt_d == '0);
    gate_hi_d = drive && raw;
    gate_lo_d = drive && !raw;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      period_sh_q    <= '0;
      duty_sh_q      <= '0;
      dt_sh_q        <= '0;
      period_act_q   <= '0;
      duty_act_q     <= '0;
      dt_act_q       <= '0;
      cnt_q          <= '0;
      dt_cnt_q       <= '0;
      enable_q       <= 1'b0;
      raw_q          <= 1'b0;
      gate_hi_q      <= 1'b0;
      gate_lo_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      period_sh_q    <= period_sh_d;
      duty_sh_q      <= duty_sh_d;
      dt_sh_q        <= dt_sh_d;
      period_act_q   <= period_act_d;
      duty_act_q     <= duty_act_d;
      dt_act_q       <= dt_act_d;
      cnt_q          <= cnt_d;
      dt_cnt_q       <= dt_cnt_d;
      enable_q       <= enable_d;
      raw_q          <= raw_d;
      gate_hi_q      <= gate_hi_d;
      gate_lo_q      <= gate_lo_d;
      period_start_q <= period_start_d;
    end
  end

  assign gate_hi      = gate_hi_q;
  assign gate_lo      = gate_lo_q;
  assign period_start = period_start_q;

endmodule

`default_nettype wire
